// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants for the keypad event filter
//
// Purpose: FSM state encoding, event kind bits, key-code names and the
//          event word layout shared by the filter and its event FIFO.
// Ports:   none (package).
package keypad_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;

  localparam logic EV_PRESS   = 1'b0;
  localparam logic EV_RELEASE = 1'b1;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam int EV_W = 5;

  // Event word: bit 4 = kind (press/release), bits 3:0 = key code.
  function automatic logic [EV_W-1:0] make_event(input logic kind, input logic [3:0] code);
    return {kind, code};
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// rtl/keypad_event_fifo.sv - first-word-fall-through event FIFO with sticky overflow
//
// Purpose: queues key events for the consumer; head is visible whenever
//          pop_valid is high. A push arriving while full is dropped unless a
//          pop happens in the same cycle; a dropped push sets overflow until reset.
// Ports:   clk, reset      - clock, synchronous active-high reset
//          push, push_data - write request and word
//          pop_valid       - FIFO non-empty
//          pop_data        - head word (0 while empty)
//          pop_ready       - consumer takes head when pop_valid && pop_ready
//          overflow        - sticky dropped-push flag
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = EV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_ready,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full      = (count == FULL_CNT);
  assign pop_valid = (count != '0);
  // Gate the head so the output reads 0 out of reset instead of stale RAM.
  assign pop_data  = pop_valid ? mem[rd_ptr] : '0;
  assign do_pop    = pop_ready && pop_valid;
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/keypad_event_filter.sv
// rtl/keypad_event_filter.sv - debounces scanner strobes into press/release events
//
// Purpose: turns the row scanner's periodic key_valid strobes into debounced
//          press and release events queued for the UI/CPU, and reports the
//          currently held key.
// Ports:   clk, reset          - clock, synchronous active-high reset
//          key_code, key_valid - scanner stream (code sampled only with valid)
//          ev_data, ev_valid   - event head {release, code} / FIFO non-empty
//          ev_ready            - consumer accept
//          key_held, held_code - debounced held-key state
//          overflow            - sticky, an event was dropped on a full FIFO
module keypad_event_filter
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD     = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RELEASE_CYCLES  = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      key_code,
  input  logic            key_valid,
  output logic [EV_W-1:0] ev_data,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic            key_held,
  output logic [3:0]      held_code,
  output logic            overflow
);

  localparam int GW = $clog2(RELEASE_CYCLES + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [GW-1:0] REL_C    = GW'(RELEASE_CYCLES);
  localparam logic [GW-1:0] SCAN_C   = GW'(SCAN_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      state, state_n;
  logic [3:0]      cand, cand_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      held_n;
  logic [GW-1:0]   gap, gap_next;
  logic            push;
  logic [EV_W-1:0] push_data;

  // Cycles since the last strobe, saturating. Decisions use the value the
  // counter takes at this edge so a release lands exactly RELEASE_CYCLES
  // cycles after the last strobe.
  always_comb begin
    gap_next = gap;
    if (key_valid)          gap_next = '0;
    else if (gap != REL_C)  gap_next = gap + 1'b1;
  end

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    held_n    = held_code;
    push      = 1'b0;
    push_data = make_event(EV_PRESS, cand);
    case (state)
      ST_IDLE: begin
        if (key_valid) begin
          cand_n  = key_code;
          cnt_n   = '0;
          state_n = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (key_valid && key_code != cand) begin
          cand_n = key_code;
          cnt_n  = '0;
        end else if (gap_next >= SCAN_C) begin
          state_n = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n   = ST_PRESSED;
          held_n    = cand;
          push      = 1'b1;
          push_data = make_event(EV_PRESS, cand);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        // Strobes of other codes only keep the gap at zero; no rollover.
        if (gap_next == REL_C) begin
          push      = 1'b1;
          push_data = make_event(EV_RELEASE, held_code);
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cnt       <= '0;
      gap       <= '0;
      held_code <= '0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      gap       <= gap_next;
      held_code <= held_n;
    end
  end

  assign key_held = (state == ST_PRESSED);

  keypad_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EV_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop_valid(ev_valid),
    .pop_data (ev_data),
    .pop_ready(ev_ready),
    .overflow (overflow)
  );

endmodule
